// File: rtl/refill_line_builder.sv
// refill_line_builder
// Collects one burst of in-order memory read beats into a full cache line,
// merges an optional pending store word, writes the line into the data array
// in a single cycle, forwards the critical load word and pulses completion.
//
// Handshakes (valid/ready):
//   - A request transfers on a rising edge where req_valid && req_ready.
//   - A memory beat transfers on a rising edge where mem_rvalid && mem_rready.
//   - The producer may assert valid at any time. Nothing transfers while
//     ready is low, and any beat offered outside RECV is ignored.
//
// The FSM state is kept in the 'state' signal (type state_t) so that checkers
// can bind to it directly.
module refill_line_builder #(
  parameter int LINE_WIDTH   = 256,
  parameter int BEAT_WIDTH   = 32,
  parameter int BEATS        = 8,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INDEX_WIDTH-1:0]  req_index,
  input  logic [OFFSET_WIDTH-1:0] req_offset,
  input  logic                    req_wen,
  input  logic [3:0]              req_wstrb,
  input  logic [BEAT_WIDTH-1:0]   req_wdata,
  input  logic [BEAT_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_rvalid,
  input  logic                    mem_rlast,
  output logic                    mem_rready,
  output logic                    arr_wen,
  output logic [INDEX_WIDTH-1:0]  arr_waddr,
  output logic [LINE_WIDTH-1:0]   arr_wdata,
  output logic                    crit_valid,
  output logic [BEAT_WIDTH-1:0]   crit_data,
  output logic                    refill_done
);

  localparam int STRB_WIDTH = BEAT_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Beat counter: index of the next word to be filled.
  logic [OFFSET_WIDTH-1:0] cnt;

  // Line buffer held as an array of words; word k sits at bits [32k+31:32k].
  logic [BEATS-1:0][BEAT_WIDTH-1:0] line_buf;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] line_nxt;

  // Request fields latched at the handshake.
  logic [INDEX_WIDTH-1:0]  idx_q;
  logic [OFFSET_WIDTH-1:0] off_q;
  logic                    wen_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [BEAT_WIDTH-1:0]   wdata_q;

  logic                  req_fire;
  logic                  beat_fire;
  logic                  beat_hit;
  logic                  beat_final;
  logic [BEAT_WIDTH-1:0] beat_word;

  assign req_ready  = (state == IDLE);
  assign mem_rready = (state == RECV);

  assign req_fire   = req_valid && req_ready;
  assign beat_fire  = mem_rvalid && mem_rready;
  assign beat_hit   = (cnt == off_q);
  // The beat in the last slot ends the burst even if rlast is missing,
  // so the counter cannot run past the end of the line.
  assign beat_final = mem_rlast || (cnt == OFFSET_WIDTH'(BEATS - 1));

  // Incoming beat with the pending store bytes merged over it when this is
  // the word the store targets.
  always_comb begin
    beat_word = mem_rdata;
    if (wen_q && beat_hit) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_q[b]) begin
          beat_word[8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Line buffer as it will look after the current beat lands; this is also
  // what goes to the array when the beat is the final one.
  always_comb begin
    line_nxt      = line_buf;
    line_nxt[cnt] = beat_word;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = RECV;
      RECV:    if (beat_fire && beat_final) state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch, beat counter and line buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      off_q    <= '0;
      wen_q    <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      line_buf <= '0;
    end else if (req_fire) begin
      idx_q    <= req_index;
      off_q    <= req_offset;
      wen_q    <= req_wen;
      wstrb_q  <= req_wstrb;
      wdata_q  <= req_wdata;
      cnt      <= '0;
      // Cleared so words missing after an early rlast are written as zero.
      line_buf <= '0;
    end else if (beat_fire) begin
      line_buf <= line_nxt;
      cnt      <= cnt + OFFSET_WIDTH'(1);
    end
  end

  // Registered outputs: array write in the cycle after the final beat,
  // critical word in the cycle after its beat, done in the cycle after the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_wen     <= 1'b0;
      arr_waddr   <= '0;
      arr_wdata   <= '0;
      crit_valid  <= 1'b0;
      crit_data   <= '0;
      refill_done <= 1'b0;
    end else begin
      arr_wen     <= beat_fire && beat_final;
      crit_valid  <= beat_fire && !wen_q && beat_hit;
      refill_done <= (state == WRITE);
      if (beat_fire && beat_final) begin
        arr_waddr <= idx_q;
        arr_wdata <= line_nxt;
      end
      if (beat_fire && !wen_q && beat_hit) begin
        crit_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_refill_line_builder.sv
// Bench for refill_line_builder: directed refills from the test plan plus
// randomized refills, with a line-level reference model feeding expected
// queues that a negedge monitor drains.
module tb_refill_line_builder;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_index;
  logic [2:0]   req_offset;
  logic         req_wen;
  logic [3:0]   req_wstrb;
  logic [31:0]  req_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_rvalid;
  logic         mem_rlast;
  logic         mem_rready;
  logic         arr_wen;
  logic [5:0]   arr_waddr;
  logic [255:0] arr_wdata;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         refill_done;

  refill_line_builder dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .req_offset  (req_offset),
    .req_wen     (req_wen),
    .req_wstrb   (req_wstrb),
    .req_wdata   (req_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .mem_rlast   (mem_rlast),
    .mem_rready  (mem_rready),
    .arr_wen     (arr_wen),
    .arr_waddr   (arr_waddr),
    .arr_wdata   (arr_wdata),
    .crit_valid  (crit_valid),
    .crit_data   (crit_data),
    .refill_done (refill_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] exp_line_q[$];
  logic [5:0]   exp_addr_q[$];
  int           exp_line_cyc_q[$];
  logic [31:0]  exp_crit_q[$];
  int           exp_crit_cyc_q[$];

  logic [31:0] beat_tab [8];
  logic        rlast_on_8;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int  last_wen_cyc = -10;
  bit  ready_due    = 1'b0;

  always @(negedge clk) begin
    if (ready_due) begin
      check("req_ready_after_done", 256'(req_ready), 256'(1));
      ready_due = 1'b0;
    end
    if (arr_wen === 1'b1) begin
      if (exp_line_q.size() == 0) begin
        check("unexpected_arr_wen", 256'(arr_wen), 256'(0));
      end else begin
        check("arr_waddr", 256'(arr_waddr), 256'(exp_addr_q.pop_front()));
        check("arr_wdata", arr_wdata, exp_line_q.pop_front());
        check("arr_wen_cycle", 256'(cyc), 256'(exp_line_cyc_q.pop_front()));
      end
      last_wen_cyc = cyc;
    end
    if (crit_valid === 1'b1) begin
      if (exp_crit_q.size() == 0) begin
        check("unexpected_crit_valid", 256'(crit_valid), 256'(0));
      end else begin
        check("crit_data", 256'(crit_data), 256'(exp_crit_q.pop_front()));
        check("crit_cycle", 256'(cyc), 256'(exp_crit_cyc_q.pop_front()));
      end
    end
    if (refill_done === 1'b1) begin
      check("done_cycle", 256'(cyc), 256'(last_wen_cyc + 1));
      check("req_ready_at_done", 256'(req_ready), 256'(0));
      ready_due = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // Expected line: received words in order, store bytes merged into the
  // target word, words after an early rlast left zero.
  function automatic logic [255:0] model_line(input int nbeats, input logic [2:0] off,
                                              input logic wen, input logic [3:0] strb,
                                              input logic [31:0] wd);
    logic [255:0] line;
    logic [31:0]  w;
    line = '0;
    for (int i = 0; i < nbeats; i++) begin
      w = beat_tab[i];
      if (wen && (i == int'(off))) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) w[8*b +: 8] = wd[8*b +: 8];
        end
      end
      line[32*i +: 32] = w;
    end
    return line;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs(input bit noisy);
    req_valid  = 1'b0;
    req_index  = 6'($urandom);
    req_offset = 3'($urandom);
    req_wen    = 1'($urandom);
    req_wstrb  = 4'($urandom);
    req_wdata  = $urandom;
    mem_rvalid = noisy ? 1'($urandom) : 1'b0;
    mem_rdata  = $urandom;
    mem_rlast  = 1'($urandom);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) check("req_ready_timeout", 256'(req_ready), 256'(1));
  endtask

  // One full refill. gap_mode: 0 none, 1 alternate cycles, 2 random gaps.
  task automatic run_req(input logic [5:0] idx, input logic [2:0] off, input logic wen,
                         input logic [3:0] strb, input logic [31:0] wd, input int nbeats,
                         input int gap_mode, input bit hold_valid);
    logic [255:0] line;
    int gaps;
    int n;
    wait_ready();
    mem_rvalid = 1'b0;
    req_valid  = 1'b1;
    req_index  = idx;
    req_offset = off;
    req_wen    = wen;
    req_wstrb  = strb;
    req_wdata  = wd;
    @(negedge clk);
    if (!hold_valid) idle_inputs(1'b0);
    line = model_line(nbeats, off, wen, strb, wd);
    for (int i = 0; i < nbeats; i++) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        mem_rlast  = 1'($urandom);
        @(negedge clk);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = beat_tab[i];
      mem_rlast  = (i == nbeats - 1) ? ((nbeats == 8) ? rlast_on_8 : 1'b1) : 1'b0;
      check("mem_rready_recv", 256'(mem_rready), 256'(1));
      if (hold_valid) check("no_second_accept", 256'(req_ready), 256'(0));
      if (!wen && (i == int'(off))) begin
        exp_crit_q.push_back(beat_tab[i]);
        exp_crit_cyc_q.push_back(cyc + 1);
      end
      if (i == nbeats - 1) begin
        exp_line_q.push_back(line);
        exp_addr_q.push_back(idx);
        exp_line_cyc_q.push_back(cyc + 1);
      end
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    n = 0;
    while (refill_done !== 1'b1 && n < 10) begin
      if (hold_valid) check("no_second_accept", 256'(req_ready), 256'(0));
      @(negedge clk);
      n++;
    end
    if (refill_done !== 1'b1) check("refill_done_timeout", 256'(refill_done), 256'(1));
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    rlast_on_8 = 1'b1;
    idle_inputs(1'b0);
    repeat (2) @(negedge clk);
    check("reset_req_ready", 256'(req_ready), 256'(1));
    check("reset_mem_rready", 256'(mem_rready), 256'(0));
    check("reset_arr_wen", 256'(arr_wen), 256'(0));
    check("reset_arr_waddr", 256'(arr_waddr), 256'(0));
    check("reset_arr_wdata", arr_wdata, 256'(0));
    check("reset_crit", {crit_valid, crit_data}, 256'(0));
    check("reset_done", 256'(refill_done), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Load refill, index 0x15, offset 3, beats 0x11111111..0x88888888.
    for (int i = 0; i < 8; i++) beat_tab[i] = 32'h11111111 * (i + 1);
    run_req(6'h15, 3'd3, 1'b0, 4'h0, 32'h0, 8, 0, 1'b0);
    check("directed_line_const", arr_wdata,
          256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);

    // Store refill merging into word 0.
    beat_tab[0] = 32'h11223344;
    for (int i = 1; i < 8; i++) beat_tab[i] = $urandom;
    run_req(6'h2a, 3'd0, 1'b1, 4'b0101, 32'hAABBCCDD, 8, 0, 1'b0);
    check("store_word0_const", 256'(arr_wdata[31:0]), 256'(32'h11BB33DD));

    // Alternate-cycle gaps; beat 7 carries no rlast and still ends the burst.
    for (int i = 0; i < 8; i++) beat_tab[i] = 32'h11111111 * (i + 1);
    rlast_on_8 = 1'b0;
    run_req(6'h15, 3'd3, 1'b0, 4'h0, 32'h0, 8, 1, 1'b0);
    rlast_on_8 = 1'b1;

    // Early rlast on beat 2, load offset 5 never reached.
    beat_tab[0] = 32'hA;
    beat_tab[1] = 32'hB;
    beat_tab[2] = 32'hC;
    run_req(6'h07, 3'd5, 1'b0, 4'h0, 32'h0, 3, 0, 1'b0);
    check("early_rlast_const", arr_wdata, 256'h0000000C_0000000B_0000000A);

    // Reset after four beats: nothing written, block idle next cycle.
    wait_ready();
    req_valid  = 1'b1;
    req_index  = 6'h3f;
    req_offset = 3'd6;
    req_wen    = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD0000 + 32'(i);
      mem_rlast  = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b0;
    check("abort_req_ready", 256'(req_ready), 256'(1));
    check("abort_mem_rready", 256'(mem_rready), 256'(0));
    check("abort_arr_wen", 256'(arr_wen), 256'(0));
    check("abort_arr_wdata", arr_wdata, 256'(0));
    @(negedge clk);
    for (int i = 0; i < 3; i++) beat_tab[i] = $urandom;
    run_req(6'h3f, 3'd1, 1'b1, 4'b1111, 32'h0BADF00D, 3, 0, 1'b0);

    // req_valid held high through RECV/WRITE/DONE.
    for (int i = 0; i < 8; i++) beat_tab[i] = $urandom;
    run_req(6'h11, 3'd7, 1'b0, 4'h0, 32'h0, 8, 0, 1'b1);

    // Randomized refills with idle-time noise on the beat channel.
    for (int t = 0; t < 40; t++) begin
      int nb;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
      for (int i = 0; i < 8; i++) beat_tab[i] = $urandom;
      rlast_on_8 = 1'($urandom);
      idle_inputs(1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        idle_inputs(1'b1);
      end
      run_req(6'($urandom), 3'($urandom), 1'($urandom), 4'($urandom), $urandom,
              nb, int'($urandom_range(0, 2)), 1'($urandom));
    end

    repeat (4) @(negedge clk);
    check("line_queue_empty", 256'(exp_line_q.size()), 256'(0));
    check("crit_queue_empty", 256'(exp_crit_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/refill_line_builder.md
Name: refill_line_builder

Overview:
- Sits directly upstream of the cache data array (64 sets x 256-bit lines).
- On a miss, it accepts one refill request, collects 8 in-order 32-bit memory read beats into a 256-bit line buffer, and merges an optional pending store word into that buffer.
- It then issues a single-cycle write of the whole line into the data array, forwards the critical load word as soon as it arrives, and pulses a completion flag.

Parameters:
- LINE_WIDTH, 256, cache line width in bits; equals the data array entry width.
- BEAT_WIDTH, 32, width of one memory read beat.
- BEATS, 8, beats per line (LINE_WIDTH/BEAT_WIDTH).
- INDEX_WIDTH, 6, set index width; equals the data array address width.
- OFFSET_WIDTH, 3, word-offset width (log2 BEATS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  refill request valid.
- req_ready  out  1  block idle and able to accept a request.
- req_index  in  INDEX_WIDTH  target set.
- req_offset  in  OFFSET_WIDTH  word offset of the missing access.
- req_wen  in  1  1 = store miss (merge); 0 = load miss (forward).
- req_wstrb  in  4  store byte strobes.
- req_wdata  in  BEAT_WIDTH  store data.
- mem_rdata  in  BEAT_WIDTH  memory read beat.
- mem_rvalid  in  1  beat valid.
- mem_rlast  in  1  final beat of burst.
- mem_rready  out  1  block accepting beats.
- arr_wen  out  1  data array write enable.
- arr_waddr  out  INDEX_WIDTH  data array write address.
- arr_wdata  out  LINE_WIDTH  data array write data.
- crit_valid  out  1  critical load word available (1-cycle pulse).
- crit_data  out  BEAT_WIDTH  critical load word.
- refill_done  out  1  line written; data array readable (1-cycle pulse).

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high on rst.
- States: IDLE, RECV, WRITE, DONE.
- Reset (any state, including mid-burst): state <- IDLE, beat counter <- 0, line buffer <- 0, latched request fields <- 0.
  - Registered outputs reset to 0: arr_wen, arr_waddr, arr_wdata, crit_valid, crit_data, refill_done.
  - In-flight beats are dropped; no array write occurs.
- State decodes: req_ready = (state==IDLE); mem_rready = (state==RECV).
- IDLE:
  - A handshake occurs when req_valid & req_ready & !rst.
  - On handshake: latch index, offset, wen, wstrb and wdata; clear the buffer to 0; clear the counter; go to RECV.
- RECV: on each mem_rvalid (mem_rready is 1), with k = counter:
  - Buffer word k (bits [32k+31:32k]) <- mem_rdata.
  - If wen and k==offset, each byte b of word k takes req_wdata byte b where wstrb[b]=1, and mem_rdata byte b otherwise.
  - If !wen and k==offset, then crit_valid=1 and crit_data=mem_rdata in the next cycle, for exactly one cycle.
  - counter <- k+1.
  - Transition to WRITE when mem_rlast=1 or k==BEATS-1.
  - Early rlast (k<7): unreceived words remain 0. If offset was not yet reached, crit_valid never pulses.
  - A beat at k==7 with rlast=0 is still final; the counter never wraps.
- WRITE: for exactly one cycle, arr_wen=1, arr_waddr=index and arr_wdata=buffer (registered). Then go to DONE.
- DONE: refill_done=1 for exactly one cycle, then go to IDLE.
- Latency, with the final beat accepted in cycle T:
  - arr_wen is high in T+1; the data array captures the line at the end of T+1.
  - refill_done is high in T+2; the array read port already shows the new line.
  - req_ready is high from T+3.
- Other times: arr_wen, crit_valid and refill_done are 0. arr_wdata and arr_waddr hold their last values.
- mem_rvalid outside RECV is ignored.
- Back-to-back requests: at most one every BEATS+3 cycles; no overlap.

Test Plan:
- Reset, then a load refill with index=0x15, offset=3 and beats 0x11111111..0x88888888 sent one per cycle with rlast on beat 7.
  - crit_valid pulses once with crit_data=0x44444444, the cycle after beat 3.
  - arr_wen pulses once with arr_waddr=0x15 and arr_wdata=0x88888888_..._11111111.
  - refill_done follows one cycle later; req_ready returns one cycle after that.
- Store refill with offset=0, wstrb=4'b0101, wdata=0xAABBCCDD, beat0=0x11223344.
  - arr_wdata[31:0]=0x11BB33DD.
  - crit_valid never asserts.
- Beats with mem_rvalid gaps (valid on alternate cycles).
  - The line is identical to the gap-free case.
  - The counter advances only on valid beats.
- Early rlast on beat 2 (beats 0xA,0xB,0xC) with offset=5, load.
  - arr_wdata = 0x..._0000000C_0000000B_0000000A, upper five words 0.
  - crit_valid never asserts; refill_done still pulses.
- rst asserted after 4 beats.
  - Next cycle: state IDLE, req_ready=1, mem_rready=0, no arr_wen.
  - A new request then completes normally, with a buffer free of stale words.
- req_valid held high during RECV/WRITE/DONE: no second acceptance until req_ready is high.
